// File: rtl/wvb_evt_wr_ctrl.sv
// Waveform-buffer event write controller: opens an event on a qualified trigger,
// streams buffer writes, and presents one header record on the event's final write.
module wvb_evt_wr_ctrl #(
  parameter int P_ADR_WIDTH   = 12,
  parameter int P_LTC_WIDTH   = 48,
  parameter int P_POST_WIDTH  = 8,
  parameter int P_FIX_WIDTH   = 12,
  parameter int P_NTRIG_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     trig,
  input  logic [1:0]               trig_src,
  input  logic                     trig_mode,
  input  logic                     arm,
  input  logic                     cnst_run,
  input  logic                     overflow_in,
  input  logic [P_LTC_WIDTH-1:0]   ltc,
  input  logic [P_POST_WIDTH-1:0]  post_config,
  input  logic [P_FIX_WIDTH-1:0]   fix_config,
  input  logic [P_ADR_WIDTH-1:0]   max_len_config,
  output logic                     wvb_wren,
  output logic [P_ADR_WIDTH-1:0]   wvb_wr_addr,
  output logic                     hdr_wren,
  output logic [P_LTC_WIDTH-1:0]   hdr_ltc,
  output logic [P_ADR_WIDTH-1:0]   hdr_start_addr,
  output logic [P_ADR_WIDTH-1:0]   hdr_stop_addr,
  output logic [P_ADR_WIDTH-1:0]   hdr_evt_len,
  output logic [P_NTRIG_WIDTH-1:0] hdr_ntrig,
  output logic [1:0]               hdr_trig_src,
  output logic                     hdr_trunc,
  output logic                     hdr_ovfl,
  output logic                     armed,
  output logic                     overflow_out
);
  localparam int CNT_W = ((P_ADR_WIDTH > P_FIX_WIDTH) ? P_ADR_WIDTH : P_FIX_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, FIXED} state_t;
  state_t state, state_nxt;

  logic [P_POST_WIDTH-1:0]  post_len, post_cnt;
  logic [CNT_W-1:0]         fix_len, max_len, wr_cnt, cnt_now;
  logic [P_LTC_WIDTH-1:0]   ltc_q, cur_ltc;
  logic [P_ADR_WIDTH-1:0]   start_q, cur_start, stop_q, len_q;
  logic [P_NTRIG_WIDTH-1:0] ntrig_q, cur_ntrig;
  logic [1:0]               src_q, cur_src;
  logic                     trunc_q, ovfl_q;
  logic                     open, fixed_src, retrig, norm_end, cap_end;

  assign open      = (state == IDLE) && trig && !overflow_out && (!trig_mode || armed);
  assign fixed_src = (trig_src == 2'b01) || (trig_src == 2'b10);
  assign retrig    = (state == ACTIVE) && trig;
  // Count of writes including the one happening this cycle.
  assign cnt_now   = open ? CNT_W'(1) : wr_cnt + CNT_W'(1);
  assign norm_end  = ((state == ACTIVE) && (post_cnt == '0) && !trig) ||
                     ((state == FIXED) && (cnt_now == fix_len));
  assign cap_end   = (cnt_now == max_len) && !norm_end;

  assign cur_ltc   = open ? ltc : ltc_q;
  assign cur_start = open ? wvb_wr_addr : start_q;
  assign cur_src   = open ? trig_src : src_q;
  assign cur_ntrig = open ? P_NTRIG_WIDTH'(1) :
                     (retrig && (ntrig_q != '1)) ? ntrig_q + P_NTRIG_WIDTH'(1) : ntrig_q;

  always_ff @(posedge clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && open)
      state_nxt = (fixed_src || cnst_run) ? FIXED : ACTIVE;
    if (hdr_wren || overflow_in || overflow_out)
      state_nxt = IDLE;
  end

  always_comb begin
    wvb_wren = !i_rst && !overflow_out && (open || state != IDLE);
    hdr_wren = wvb_wren && (overflow_in || norm_end || cap_end);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wvb_wr_addr  <= '0;
      post_cnt     <= '0;
      wr_cnt       <= '0;
      post_len     <= P_POST_WIDTH'(2);
      fix_len      <= CNT_W'(2);
      max_len      <= CNT_W'(4);
      ltc_q        <= '0;
      start_q      <= '0;
      stop_q       <= '0;
      len_q        <= '0;
      ntrig_q      <= '0;
      src_q        <= '0;
      trunc_q      <= 1'b0;
      ovfl_q       <= 1'b0;
      armed        <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      overflow_out <= overflow_out | overflow_in;
      armed        <= arm | (armed & ~hdr_wren);
      if (state == IDLE) begin
        post_len <= (post_config < P_POST_WIDTH'(2)) ? P_POST_WIDTH'(2) : post_config;
        fix_len  <= CNT_W'((fix_config < P_FIX_WIDTH'(2)) ? P_FIX_WIDTH'(2) : fix_config);
        max_len  <= CNT_W'((max_len_config < P_ADR_WIDTH'(4)) ? P_ADR_WIDTH'(4) : max_len_config);
      end
      if (wvb_wren) begin
        wvb_wr_addr <= wvb_wr_addr + P_ADR_WIDTH'(1);
        wr_cnt      <= cnt_now;
        ltc_q       <= cur_ltc;
        start_q     <= cur_start;
        src_q       <= cur_src;
        ntrig_q     <= cur_ntrig;
        post_cnt    <= (open || retrig) ? post_len - P_POST_WIDTH'(1)
                                        : post_cnt - P_POST_WIDTH'(1);
      end
      if (hdr_wren) begin
        stop_q  <= wvb_wr_addr;
        len_q   <= P_ADR_WIDTH'(cnt_now);
        trunc_q <= cap_end;
        ovfl_q  <= overflow_in;
      end
    end
  end

  // Live values on the final write, held copies afterwards until the next open.
  assign hdr_ltc        = hdr_wren ? cur_ltc : ltc_q;
  assign hdr_start_addr = hdr_wren ? cur_start : start_q;
  assign hdr_stop_addr  = hdr_wren ? wvb_wr_addr : stop_q;
  assign hdr_evt_len    = hdr_wren ? P_ADR_WIDTH'(cnt_now) : len_q;
  assign hdr_ntrig      = hdr_wren ? cur_ntrig : ntrig_q;
  assign hdr_trig_src   = hdr_wren ? cur_src : src_q;
  assign hdr_trunc      = hdr_wren ? cap_end : trunc_q;
  assign hdr_ovfl       = hdr_wren ? overflow_in : ovfl_q;

endmodule

// File: tb/tb_wvb_evt_wr_ctrl.sv
// Randomized bench for wvb_evt_wr_ctrl; an event-level model predicts each
// write address, the final write and the header it carries.
module tb_wvb_evt_wr_ctrl;
  localparam int AW = 12, LW = 48, PW = 8, FW = 12, NW = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          trig = 1'b0, trig_mode = 1'b0, arm = 1'b0, cnst_run = 1'b0, overflow_in = 1'b0;
  logic [1:0]    trig_src = 2'b00;
  logic [LW-1:0] ltc = '0;
  logic [PW-1:0] post_config = '0;
  logic [FW-1:0] fix_config = '0;
  logic [AW-1:0] max_len_config = '0;
  logic          wvb_wren, hdr_wren, hdr_trunc, hdr_ovfl, armed, overflow_out;
  logic [AW-1:0] wvb_wr_addr, hdr_start_addr, hdr_stop_addr, hdr_evt_len;
  logic [LW-1:0] hdr_ltc;
  logic [NW-1:0] hdr_ntrig;
  logic [1:0]    hdr_trig_src;

  wvb_evt_wr_ctrl dut (
    .clk(clk), .i_rst(i_rst), .trig(trig), .trig_src(trig_src), .trig_mode(trig_mode),
    .arm(arm), .cnst_run(cnst_run), .overflow_in(overflow_in), .ltc(ltc),
    .post_config(post_config), .fix_config(fix_config), .max_len_config(max_len_config),
    .wvb_wren(wvb_wren), .wvb_wr_addr(wvb_wr_addr), .hdr_wren(hdr_wren), .hdr_ltc(hdr_ltc),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr), .hdr_evt_len(hdr_evt_len),
    .hdr_ntrig(hdr_ntrig), .hdr_trig_src(hdr_trig_src), .hdr_trunc(hdr_trunc),
    .hdr_ovfl(hdr_ovfl), .armed(armed), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int addr_m = 0;
  logic ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    ltc = ltc + 48'd1;
  endtask

  task automatic idle(input int n);
    trig = 1'b0; arm = 1'b0; overflow_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_wren", 64'(wvb_wren), 64'(0));
      step();
    end
  endtask

  // Trigger held high while writes must stay blocked.
  task automatic blocked(input int n, input logic ovf_exp);
    trig = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("blk_wren", 64'(wvb_wren), 64'(0));
      chk("blk_hdr", 64'(hdr_wren), 64'(0));
      chk("blk_ovf", 64'(overflow_out), 64'(ovf_exp));
      step();
    end
    trig = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; trig = 1'b0; arm = 1'b0; overflow_in = 1'b0;
    @(negedge clk);
    chk("rst_wren", 64'(wvb_wren), 64'(0));
    chk("rst_hdr_wren", 64'(hdr_wren), 64'(0));
    step();
    i_rst = 1'b0;
    addr_m = 0; ovf_m = 1'b0;
    @(negedge clk);
    chk("rst_addr", 64'(wvb_wr_addr), 64'(0));
    chk("rst_armed", 64'(armed), 64'(0));
    chk("rst_ovf", 64'(overflow_out), 64'(0));
    chk("rst_hdr", {hdr_ltc, hdr_start_addr, hdr_ntrig[3:0]}, 64'(0));
    chk("rst_hdr2", {hdr_stop_addr, hdr_evt_len, hdr_trig_src, hdr_trunc, hdr_ovfl}, 64'(0));
    step();
  endtask

  task automatic run_event(input logic [1:0] src, input logic cr, input int pcfg, input int fcfg,
                           input int mcfg, input int pct, input int trig_at, input int ovf_at,
                           input int arm_at);
    int postl, fixl, maxl, k, last, nt, start;
    logic fixed, normal, cap, fin, done;
    logic [LW-1:0] ltc0;
    trig_src = src; cnst_run = cr;
    post_config = PW'(pcfg); fix_config = FW'(fcfg); max_len_config = AW'(mcfg);
    idle(2);
    postl = (pcfg < 2) ? 2 : pcfg;
    fixl  = (fcfg < 2) ? 2 : fcfg;
    maxl  = (mcfg < 4) ? 4 : mcfg;
    fixed = (src == 2'b01) || (src == 2'b10) || cr;
    k = 0; last = 1; nt = 1; start = addr_m; done = 1'b0; ltc0 = ltc;
    while (!done && k < 5000) begin
      k++;
      trig = (k == 1) || (k == trig_at) || ($urandom_range(99) < pct);
      overflow_in = (k == ovf_at);
      arm = (k == arm_at);
      if (k == 1) ltc0 = ltc;
      if (!fixed && k > 1 && trig) begin
        last = k;
        if (nt < 255) nt++;
      end
      normal = fixed ? (k == fixl) : (k - last == postl);
      cap = (k == maxl) && !normal;
      fin = overflow_in || normal || cap;
      @(negedge clk);
      chk("wren", 64'(wvb_wren), 64'(1));
      chk("addr", 64'(wvb_wr_addr), 64'(addr_m));
      chk("hdr_wren", 64'(hdr_wren), 64'(fin));
      if (fin) begin
        chk("h_start", 64'(hdr_start_addr), 64'(start));
        chk("h_stop", 64'(hdr_stop_addr), 64'(addr_m));
        chk("h_len", 64'(hdr_evt_len), 64'(k));
        chk("h_ntrig", 64'(hdr_ntrig), 64'(fixed ? 1 : nt));
        chk("h_src", 64'(hdr_trig_src), 64'(src));
        chk("h_trunc", 64'(hdr_trunc), 64'(cap));
        chk("h_ovfl", 64'(hdr_ovfl), 64'(overflow_in));
        chk("h_ltc", 64'(hdr_ltc), 64'(ltc0));
        if (overflow_in) ovf_m = 1'b1;
        done = 1'b1;
      end
      addr_m = (addr_m + 1) % 4096;
      step();
    end
    trig = 1'b0; arm = 1'b0; overflow_in = 1'b0;
    if (!done) chk("evt_end", 64'(hdr_wren), 64'(1));
    else begin
      @(negedge clk);
      chk("post_wren", 64'(wvb_wren), 64'(0));
      chk("post_armed", 64'(armed), 64'(arm_at == k));
      chk("hold_len", 64'(hdr_evt_len), 64'(k));
      chk("hold_start", 64'(hdr_start_addr), 64'(start));
      chk("post_ovf", 64'(overflow_out), 64'(ovf_m));
      step();
    end
  endtask

  task automatic arm_now();
    arm = 1'b1; step(); arm = 1'b0;
    @(negedge clk);
    chk("armed_set", 64'(armed), 64'(1));
    step();
  endtask

  initial begin
    int l;
    ltc = {16'($urandom), 32'($urandom)};
    do_reset();
    // single threshold trigger, then one retrigger two cycles after open
    run_event(2'b00, 1'b0, 4, 10, 4095, 0, 0, 0, 0);
    do_reset();
    run_event(2'b00, 1'b0, 4, 10, 4095, 0, 3, 0, 0);
    // length cap with trigger every cycle, then software fixed-length event
    run_event(2'b00, 1'b0, 4, 10, 6, 100, 0, 0, 0);
    run_event(2'b01, 1'b0, 4, 10, 4095, 50, 0, 0, 0);
    run_event(2'b10, 1'b0, 0, 0, 0, 30, 0, 0, 0);
    run_event(2'b00, 1'b1, 4, 3, 4095, 40, 0, 0, 0);
    // armed-mode gating
    trig_mode = 1'b1;
    blocked(3, 1'b0);
    arm_now();
    run_event(2'b00, 1'b0, 3, 5, 4095, 20, 0, 0, 0);
    blocked(2, 1'b0);
    arm_now();
    run_event(2'b01, 1'b0, 3, 6, 4095, 20, 0, 0, 6);
    trig_mode = 1'b0;
    for (int n = 0; n < 25; n++) begin
      int r, mc, am;
      r  = $urandom_range(2);
      mc = (r == 0) ? $urandom_range(3) : (r == 1) ? $urandom_range(20, 5) : 4095;
      am = $urandom_range(8);
      trig_mode = 1'($urandom_range(1));
      if (trig_mode) arm_now();
      run_event(2'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(6),
                $urandom_range(14), mc, $urandom_range(50), 0, 0, am);
    end
    trig_mode = 1'b0;
    // single-sample event ended by overflow on its open cycle
    run_event(2'b00, 1'b0, 4, 4, 4095, 0, 0, 1, 0);
    blocked(3, 1'b1);
    do_reset();
    // overflow with no write in progress
    idle(1);
    overflow_in = 1'b1;
    @(negedge clk);
    chk("ovi_wren", 64'(wvb_wren), 64'(0));
    chk("ovi_hdr", 64'(hdr_wren), 64'(0));
    step();
    overflow_in = 1'b0;
    blocked(3, 1'b1);
    do_reset();
    // reset in the middle of an event aborts it without a header
    trig_src = 2'b00; cnst_run = 1'b0; post_config = 8'd6;
    idle(2);
    trig = 1'b1; step(); trig = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_wren", 64'(wvb_wren), 64'(1));
      step();
    end
    do_reset();
    idle(2);
    // walk the address to 4094, then overflow on the third write across the wrap
    l = (4094 - addr_m + 4096) % 4096;
    if (l < 2) run_event(2'b01, 1'b0, 2, 4, 4095, 0, 0, 0, 0);
    l = (4094 - addr_m + 4096) % 4096;
    run_event(2'b01, 1'b0, 2, l, 4095, 10, 0, 0, 0);
    run_event(2'b10, 1'b0, 2, 10, 4095, 10, 0, 3, 0);
    blocked(4, 1'b1);
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wvb_evt_wr_ctrl.md
WVB_EVT_WR_CTRL -- requirements
Module: wvb_evt_wr_ctrl

Interface
REQ-001 Parameter P_ADR_WIDTH, default 12: waveform buffer address width.
REQ-002 Parameter P_LTC_WIDTH, default 48: local time counter width.
REQ-003 Parameter P_POST_WIDTH, default 8: post-trigger length config width.
REQ-004 Parameter P_FIX_WIDTH, default 12: fixed-length (test/constant) config width.
REQ-005 Parameter P_NTRIG_WIDTH, default 8: retrigger counter width.
REQ-006 clk  input  1  clock; reset i_rst, synchronous, active-high.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 trig  input  1  sample-over-threshold or software/external trigger strobe.
REQ-009 trig_src  input  2  trigger source; 2'b01 = SW, 2'b10 = EXT, other = threshold.
REQ-010 trig_mode  input  1  0 = free-running; 1 = event opens only when armed.
REQ-011 arm  input  1  arm strobe.
REQ-012 cnst_run  input  1  constant-length run mode for threshold triggers.
REQ-013 overflow_in  input  1  buffer overflow from downstream.
REQ-014 ltc  input  P_LTC_WIDTH  current local time.
REQ-015 post_config / fix_config / max_len_config  input  P_POST_WIDTH / P_FIX_WIDTH / P_ADR_WIDTH  post length, fixed length, event length cap.
REQ-016 wvb_wren  output  1  buffer write enable; wvb_wr_addr  output  P_ADR_WIDTH  write address.
REQ-017 hdr_wren  output  1  header write strobe, asserted on the final write of an event.
REQ-018 hdr_ltc, hdr_start_addr, hdr_stop_addr, hdr_evt_len, hdr_ntrig, hdr_trig_src, hdr_trunc, hdr_ovfl  output  P_LTC_WIDTH, P_ADR_WIDTH x3, P_NTRIG_WIDTH, 2, 1, 1  header fields.
REQ-019 armed, overflow_out  output  1 each  arm status, sticky overflow.

Function
REQ-020 FSM states: IDLE, ACTIVE (threshold event), FIXED (SW/EXT or cnst_run event).
REQ-021 Open condition (IDLE): trig && !overflow_out && (trig_mode==0 || armed); this cycle performs the first write.
REQ-022 Open transition: SW/EXT -> FIXED; else cnst_run -> FIXED; else -> ACTIVE.
REQ-023 Config latch in IDLE each cycle: post_len = max(post_config,2), fix_len = max(fix_config,2), max_len = max(max_len_config,4).
REQ-024 At open: hdr_ltc <= ltc, hdr_start_addr <= wvb_wr_addr, hdr_trig_src <= trig_src, hdr_ntrig <= 1, post counter <= post_len-1.
REQ-025 wvb_wren = 1 on the open cycle and every cycle in ACTIVE/FIXED; 0 otherwise, and 0 whenever overflow_out=1.
REQ-026 wvb_wr_addr increments by 1 after every write, wrapping modulo 2^P_ADR_WIDTH.
REQ-027 ACTIVE: trig reloads post counter to post_len-1 and increments hdr_ntrig, saturating at all-ones; otherwise post counter decrements.
REQ-028 ACTIVE final write: post counter==0 && !trig; event length = 1 + post_len after the last trigger.
REQ-029 FIXED final write: write count == fix_len; trig ignored, hdr_ntrig stays 1.
REQ-030 Cap: if write count reaches max_len before the normal end, that write is final, hdr_trunc=1.
REQ-031 overflow_in coincident with a write makes that write final with hdr_ovfl=1; overflow_out set next cycle, held until reset.
REQ-032 overflow_in with no write sets overflow_out; no header written; FSM forced to IDLE.
REQ-033 hdr_wren = wvb_wren on final write; same cycle: hdr_stop_addr = wvb_wr_addr, hdr_evt_len = write count (incl. final); FSM -> IDLE next cycle.
REQ-034 Header fields stable from hdr_wren until next open.
REQ-035 armed: set by arm; cleared by hdr_wren; arm and hdr_wren same cycle -> armed=1.
REQ-036 Single-sample event (open cycle also final via overflow_in) produces hdr_evt_len=1, start_addr==stop_addr.

Reset
REQ-037 i_rst: FSM IDLE, wvb_wr_addr 0, counters 0, armed 0, overflow_out 0, all header outputs 0, wvb_wren/hdr_wren 0 in the reset cycle.
REQ-038 i_rst mid-event aborts the event with no header write.

Verification
REQ-039 post_config=4, addr 0, single threshold trig -> 5 writes addr 0..4, hdr_wren on addr 4, evt_len=5, ntrig=1.
REQ-040 post_config=4, retrig 2 cycles after open -> evt_len=7, ntrig=2, stop_addr=6.
REQ-041 max_len_config=6, trig every cycle -> writes 6, hdr_trunc=1, evt_len=6.
REQ-042 trig_src=SW, fix_config=10, extra trigs mid-event -> evt_len=10, ntrig=1.
REQ-043 trig_mode=1 unarmed trig -> no write; arm, trig -> event; armed clears on hdr_wren.
REQ-044 overflow_in at 3rd write -> hdr_ovfl=1, evt_len=3, then no writes until i_rst; addr start 4094 wraps to 0.
